program_loader_ctrl: RTL and testbench

//  Sequences boot-time loading of the instruction memory from a byte-wide source (UART/debug port).

---
 rtl/loader_pkg.sv | 5 +
 rtl/program_loader_ctrl_byte_assembler.sv | 41 ++++
 rtl/program_loader_ctrl.sv | 112 +++++++++++
 tb/tb_program_loader_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types for the boot-time program loader.
package loader_pkg;
    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, RUN, FAULT} loader_state_t;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/program_loader_ctrl_byte_assembler.sv
// Packs a big-endian byte stream into 32-bit words; the first byte ends up in [31:24].
module byte_assembler
    import loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic        word_complete,
    output logic [31:0] word
);
    logic [1:0]  idx_q, idx_d;
    logic [23:0] shift_q, shift_d;

    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        if (clear) begin
            idx_d   = '0;
            shift_d = '0;
        end else if (shift_en) begin
            idx_d   = idx_q + 2'd1;
            shift_d = {shift_q[15:0], byte_in};
        end
    end

    // The completing byte is not stored; it is appended combinationally.
    assign word_complete = shift_en && !clear && (idx_q == 2'(BYTES_PER_WORD - 1));
    assign word          = {shift_q, byte_in};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end
endmodule

// File: rtl/program_loader_ctrl.sv
// Boot loader: streams bytes into instruction memory, holds the CPU in reset until a terminator word.
module program_loader_ctrl
    import loader_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] END_WORD = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_fault,
    output logic [ADDR_W:0]   word_count,
    output logic [2:0]        dbg_state
);
    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

    loader_state_t     state_q, state_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;

    logic        start_ok;
    logic        shift_en;
    logic        word_complete;
    logic [31:0] word;

    // start only matters outside an active load; in COLLECT/WRITE it is ignored.
    assign start_ok = start && (state_q == IDLE || state_q == RUN || state_q == FAULT);
    assign shift_en = byte_valid && (state_q == COLLECT);

    byte_assembler u_asm (
        .clock         (clock),
        .reset         (reset),
        .clear         (start_ok),
        .shift_en      (shift_en),
        .byte_in       (byte_data),
        .word_complete (word_complete),
        .word          (word)
    );

    always_comb begin
        state_d      = state_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        word_count_d = word_count_q;
        case (state_q)
            IDLE, RUN, FAULT: begin
                if (start_ok) begin
                    state_d      = COLLECT;
                    word_count_d = '0;
                    mem_addr_d   = '0;
                end
            end
            COLLECT: begin
                if (word_complete) begin
                    if (word == END_WORD) begin
                        state_d = RUN;
                    end else if (word_count_q == DEPTH_CNT) begin
                        state_d = FAULT;
                    end else begin
                        state_d     = WRITE;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = word;
                        mem_addr_d  = word_count_q[ADDR_W-1:0];
                    end
                end
            end
            WRITE: begin
                state_d      = COLLECT;
                mem_we_d     = 1'b0;
                word_count_d = word_count_q + (ADDR_W+1)'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            word_count_q <= word_count_d;
        end
    end

    assign byte_ready = (state_q == COLLECT);
    assign cpu_hold   = (state_q != RUN);
    assign load_done  = (state_q == RUN);
    assign load_fault = (state_q == FAULT);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign word_count = word_count_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_program_loader_ctrl.sv
// Directed bench for program_loader_ctrl with a word-level reference model and per-cycle compare.
module tb_program_loader_ctrl;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          byte_ready, mem_we, cpu_hold, load_done, load_fault;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   word_count;
  logic [2:0]    dbg_state;

  int total = 0;
  int bad   = 0;
  bit run_chk = 1'b1;

  // model: phase 0 idle, 1 loading, 2 running, 3 faulted
  int          m_phase = 0;
  int          m_count = 0;
  int          m_nb    = 0;
  bit          m_pend  = 1'b0;
  logic [31:0] m_buf   = '0;
  logic [AW+31:0] exp_q[$];
  int          act_addr_q[$];
  logic [31:0] act_data_q[$];

  program_loader_ctrl #(.ADDR_W(AW), .END_WORD(32'h0000_0000)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_fault (load_fault),
    .word_count (word_count),
    .dbg_state  (dbg_state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clock) begin
    if (run_chk) begin
      chk("mem_we", 64'(mem_we), 64'(m_pend));
      chk("byte_ready", 64'(byte_ready), 64'(m_phase == 1 && !m_pend));
      chk("cpu_hold", 64'(cpu_hold), 64'(m_phase != 2));
      chk("load_done", 64'(load_done), 64'(m_phase == 2));
      chk("load_fault", 64'(load_fault), 64'(m_phase == 3));
      chk("word_count", 64'(word_count), 64'(m_count));
      if (mem_we) begin
        act_addr_q.push_back(int'(mem_addr));
        act_data_q.push_back(mem_wdata);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_addr, mem_wdata);
        end else begin
          logic [AW+31:0] e;
          e = exp_q.pop_front();
          chk("mem_addr", 64'(mem_addr), 64'(e[AW+31:32]));
          chk("mem_wdata", 64'(mem_wdata), 64'(e[31:0]));
        end
      end
      if (m_pend) begin
        m_pend = 1'b0;
        m_count++;
      end
    end
  end

  task automatic model_byte(input logic [7:0] b);
    m_buf = {m_buf[23:0], b};
    m_nb++;
    if (m_nb == 4) begin
      m_nb = 0;
      if (m_buf == 32'h0) m_phase = 2;
      else if (m_count + int'(m_pend) == DEPTH) m_phase = 3;
      else begin
        exp_q.push_back({AW'(m_count), m_buf});
        m_pend = 1'b1;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    if (m_phase != 1) begin
      m_phase = 1;
      m_count = 0;
      m_nb    = 0;
      m_buf   = '0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    if (!byte_ready) begin
      total++;
      bad++;
      $display("FAIL byte_ready_timeout: got 0 expected 1 for byte %0h", b);
      byte_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    model_byte(b);
    byte_valid = 1'b0;
    byte_data  = 8'($urandom_range(0, 255));
    repeat (gap) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic clear_log();
    act_addr_q.delete();
    act_data_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
    chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
    chk({tag, "_load_done"}, 64'(load_done), 64'd0);
    chk({tag, "_load_fault"}, 64'(load_fault), 64'd0);
    chk({tag, "_word_count"}, 64'(word_count), 64'd0);
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_count = 0;
    m_nb    = 0;
    m_pend  = 1'b0;
    m_buf   = '0;
    exp_q.delete();
  endtask

  task automatic run_stream(input int gap);
    send_word(32'h8C01_0004, gap);
    send_word(32'h8C02_0008, gap);
    send_word(32'h0000_0000, gap);
    chk("stream_writes", 64'(act_addr_q.size()), 64'd2);
    if (act_addr_q.size() == 2) begin
      chk("stream_addr0", 64'(act_addr_q[0]), 64'd0);
      chk("stream_data0", 64'(act_data_q[0]), 64'h8C01_0004);
      chk("stream_addr1", 64'(act_addr_q[1]), 64'd1);
      chk("stream_data1", 64'(act_data_q[1]), 64'h8C02_0008);
    end
    chk("stream_done", 64'(load_done), 64'd1);
    chk("stream_hold", 64'(cpu_hold), 64'd0);
    chk("stream_count", 64'(word_count), 64'd2);
  endtask

  initial begin
    #1;
    check_reset_values("reset");
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // back-to-back stream
    clear_log();
    pulse_start();
    run_stream(0);

    // same stream, byte_valid on alternate cycles, reload from RUN
    clear_log();
    pulse_start();
    run_stream(1);

    // terminator as first word
    clear_log();
    pulse_start();
    send_word(32'h0000_0000, 0);
    chk("term_writes", 64'(act_addr_q.size()), 64'd0);
    chk("term_done", 64'(load_done), 64'd1);
    chk("term_count", 64'(word_count), 64'd0);
    chk("term_hold", 64'(cpu_hold), 64'd0);

    // reload from RUN, with start pulses mid-word ignored
    clear_log();
    pulse_start();
    chk("reload_hold", 64'(cpu_hold), 64'd1);
    chk("reload_done", 64'(load_done), 64'd0);
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    pulse_start();
    send_byte(8'hBE, 2);
    pulse_start();
    send_byte(8'hEF, 0);
    send_word(32'h0000_0000, 0);
    chk("reload_writes", 64'(act_addr_q.size()), 64'd1);
    if (act_addr_q.size() == 1) begin
      chk("reload_addr", 64'(act_addr_q[0]), 64'd0);
      chk("reload_data", 64'(act_data_q[0]), 64'hDEAD_BEEF);
    end

    // overflow of a 4-word memory
    clear_log();
    pulse_start();
    for (int i = 0; i < 5; i++) send_word(32'hA000_0000 + 32'(i * 17 + 1), 0);
    @(posedge clock); #1;
    chk("ovf_writes", 64'(act_addr_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < act_addr_q.size(); i++)
      chk("ovf_addr", 64'(act_addr_q[i]), 64'(i));
    chk("ovf_fault", 64'(load_fault), 64'd1);
    chk("ovf_hold", 64'(cpu_hold), 64'd1);
    chk("ovf_count", 64'(word_count), 64'd4);
    clear_log();
    pulse_start();
    chk("ovf_clear_fault", 64'(load_fault), 64'd0);
    chk("ovf_clear_count", 64'(word_count), 64'd0);
    send_word(32'hCAFE_F00D, 0);
    send_word(32'h0000_0000, 0);
    chk("ovf_restart_writes", 64'(act_addr_q.size()), 64'd1);
    if (act_addr_q.size() == 1) begin
      chk("ovf_restart_addr", 64'(act_addr_q[0]), 64'd0);
      chk("ovf_restart_data", 64'(act_data_q[0]), 64'hCAFE_F00D);
    end

    // asynchronous reset after two bytes of a word
    clear_log();
    pulse_start();
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check_reset_values("midreset");
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    pulse_start();
    send_word(32'h1122_3344, 0);
    send_word(32'h0000_0000, 0);
    chk("midreset_writes", 64'(act_addr_q.size()), 64'd1);
    if (act_addr_q.size() == 1) begin
      chk("midreset_addr", 64'(act_addr_q[0]), 64'd0);
      chk("midreset_data", 64'(act_data_q[0]), 64'h1122_3344);
    end

    repeat (3) begin
      @(posedge clock); #1;
    end
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    run_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
